// File: rtl/viterbi_pkg.sv
// Shared types and constants for the hard-decision Viterbi decoder.
// Holds the frame-controller state enum, symbol width and initial path metrics.
package viterbi_pkg;

    localparam int SIZE_DATA = 2;

    // Initial path metrics: state 0 is known, all others start penalised.
    localparam int PM_INIT_0     = 0;
    localparam int PM_INIT_OTHER = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACS,
        S_TAIL,
        S_TRACE,
        S_DONE
    } vit_ctrl_state_t;

endpackage

// File: rtl/viterbi_sym_pipe.sv
// One-stage output register for BMU symbol, ACS valid and survivor address.
// Ports: clk, rst_n, load/sym/idx in; sym_q/valid_q/idx_q registered out.
module viterbi_sym_pipe
    import viterbi_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [SIZE_DATA-1:0] sym,
    input  logic [AW-1:0]        idx,
    output logic [SIZE_DATA-1:0] sym_q,
    output logic                 valid_q,
    output logic [AW-1:0]        idx_q
);

    // Symbol and address hold their last value between loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= load;
            if (load) begin
                sym_q <= sym;
                idx_q <= idx;
            end
        end
    end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi decoder: symbol intake, PMU/survivor
// control, zero-tail insertion and traceback handshake.
// Ports: i_clk, i_rst_n, i_start, i_sym_valid/i_sym_data/o_sym_ready,
//   o_bmu_data, o_pm_valid, o_pm_init, o_surv_we, o_surv_waddr,
//   o_tb_start, i_tb_done, o_frame_done, o_busy, o_err (macro only).
// Macro VITERBI_FRAME_CTRL_TIMEOUT_EN adds the traceback watchdog and o_err.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN  = 16,
    parameter int TAIL_LEN   = 2,
    parameter int TB_TIMEOUT = 64
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic                                  i_sym_valid,
    input  logic [SIZE_DATA-1:0]                  i_sym_data,
    output logic                                  o_sym_ready,
    output logic [SIZE_DATA-1:0]                  o_bmu_data,
    output logic                                  o_pm_valid,
    output logic                                  o_pm_init,
    output logic                                  o_surv_we,
    output logic [$clog2(FRAME_LEN+TAIL_LEN)-1:0] o_surv_waddr,
    output logic                                  o_tb_start,
    input  logic                                  i_tb_done,
    output logic                                  o_frame_done,
    output logic                                  o_busy
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
    ,
    output logic                                  o_err
`endif
);

    localparam int AW = $clog2(FRAME_LEN + TAIL_LEN);
    localparam logic [AW-1:0] LAST_DATA = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(FRAME_LEN + TAIL_LEN - 1);

    if (FRAME_LEN < 2 || TAIL_LEN < 1 || TB_TIMEOUT < 1) begin : g_bad_param
        $error("viterbi_frame_ctrl: illegal parameter value");
    end

    vit_ctrl_state_t state, next_state;

    logic [AW-1:0]        load_idx;
    logic                 load;
    logic [SIZE_DATA-1:0] load_sym;
    logic                 launch;
    logic                 tb_issued;
    logic                 tb_wait;

`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TB_TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TB_TIMEOUT - 1);
    logic [WW-1:0] wd_cnt;
    logic          timeout;
`endif

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_sym   = '0;
        launch     = 1'b0;
        // done is only looked at once the launch pulse has gone out
        tb_wait    = (state == S_TRACE) && tb_issued && !o_tb_start;
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
        timeout    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (i_start) next_state = S_INIT;
            end
            S_INIT: begin
                next_state = S_ACS;
            end
            S_ACS: begin
                if (i_sym_valid) begin
                    load     = 1'b1;
                    load_sym = i_sym_data;
                    if (load_idx == LAST_DATA) next_state = S_TAIL;
                end
            end
            S_TAIL: begin
                load = 1'b1;
                if (load_idx == LAST_IDX) next_state = S_TRACE;
            end
            S_TRACE: begin
                launch = !tb_issued;
                if (tb_wait && i_tb_done) begin
                    next_state = S_DONE;
                end
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
                else if (tb_wait && wd_cnt == WD_LAST) begin
                    timeout    = 1'b1;
                    next_state = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode,
    // so each one lines up exactly with the state it describes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            o_busy       <= 1'b0;
            o_pm_init    <= 1'b0;
            o_sym_ready  <= 1'b0;
            o_frame_done <= 1'b0;
            o_tb_start   <= 1'b0;
            tb_issued    <= 1'b0;
            load_idx     <= '0;
        end else begin
            state        <= next_state;
            o_busy       <= (next_state != S_IDLE);
            o_pm_init    <= (next_state == S_INIT);
            o_sym_ready  <= (next_state == S_ACS);
            o_frame_done <= (next_state == S_DONE);
            o_tb_start   <= launch;
            tb_issued    <= (next_state == S_TRACE) && (tb_issued || launch);
            if (state == S_IDLE || state == S_DONE) begin
                load_idx <= '0;
            end else if (load && load_idx != LAST_IDX) begin
                load_idx <= load_idx + 1'b1;
            end
        end
    end

`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
            o_err  <= 1'b0;
        end else begin
            wd_cnt <= tb_wait ? wd_cnt + 1'b1 : '0;
            if (state == S_IDLE && i_start) begin
                o_err <= 1'b0;
            end else if (timeout) begin
                o_err <= 1'b1;
            end
        end
    end
`endif

    viterbi_sym_pipe #(
        .AW(AW)
    ) u_pipe (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .load   (load),
        .sym    (load_sym),
        .idx    (load_idx),
        .sym_q  (o_bmu_data),
        .valid_q(o_pm_valid),
        .idx_q  (o_surv_waddr)
    );

    assign o_surv_we = o_pm_valid;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed self-checking bench for viterbi_frame_ctrl (FRAME_LEN=4, TAIL_LEN=2).
// Define VITERBI_FRAME_CTRL_TIMEOUT_EN to also cover the watchdog.
module tb_viterbi_frame_ctrl;

    localparam int FL = 4;
    localparam int TL = 2;
    localparam int TO = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sym_valid = 1'b0;
    logic [1:0]    sym_data = 2'b00;
    logic          tb_done = 1'b0;
    logic          sym_ready;
    logic [1:0]    bmu_data;
    logic          pm_valid;
    logic          pm_init;
    logic          surv_we;
    logic [AW-1:0] surv_waddr;
    logic          tb_start;
    logic          frame_done;
    logic          busy;
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .FRAME_LEN (FL),
        .TAIL_LEN  (TL),
        .TB_TIMEOUT(TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_sym_valid (sym_valid),
        .i_sym_data  (sym_data),
        .o_sym_ready (sym_ready),
        .o_bmu_data  (bmu_data),
        .o_pm_valid  (pm_valid),
        .o_pm_init   (pm_init),
        .o_surv_we   (surv_we),
        .o_surv_waddr(surv_waddr),
        .o_tb_start  (tb_start),
        .i_tb_done   (tb_done),
        .o_frame_done(frame_done),
        .o_busy      (busy)
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
        ,
        .o_err       (err)
`endif
    );

    // Leaves the bench at the negedge of cycle E+2 (sym_ready high).
    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst_n = 1'b0;
        @(negedge clk);
        got = {sym_ready, bmu_data, pm_valid, pm_init, surv_we,
               surv_waddr, tb_start, frame_done, busy};
        n_checks++;
        if (got !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", got);
        end
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (pm_init !== 1'b1) begin
            n_fail++;
            $display("FAIL init_high: got %b want 1", pm_init);
        end
        n_checks++;
        if ({sym_ready, pm_valid, tb_start, frame_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL init_others: got %b want 0000",
                     {sym_ready, pm_valid, tb_start, frame_done});
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_busy: got %b want 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (pm_init !== 1'b0 || sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_to_acs: init %b ready %b want 0 1",
                     pm_init, sym_ready);
        end
    endtask

    // Entered at negedge E+2; leaves at negedge one cycle after tb_start.
    task automatic test_continuous();
        logic [1:0] syms [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [1:0] dtab [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
        logic       ev;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                ev = (c <= 6);
                n_checks++;
                if (pm_valid !== ev || surv_we !== ev) begin
                    n_fail++;
                    $display("FAIL cont_valid c%0d: pm %b we %b want %b",
                             c, pm_valid, surv_we, ev);
                end
                if (ev) begin
                    n_checks++;
                    if (bmu_data !== dtab[c-1]
                        || surv_waddr !== AW'(c - 1)) begin
                        n_fail++;
                        $display("FAIL cont_data c%0d: d %b a %0d want %b %0d",
                                 c, bmu_data, surv_waddr, dtab[c-1], c - 1);
                    end
                end
                n_checks++;
                if (tb_start !== (c == 7)) begin
                    n_fail++;
                    $display("FAIL cont_tbstart c%0d: got %b want %b",
                             c, tb_start, c == 7);
                end
            end
            n_checks++;
            if (sym_ready !== (c < 4)) begin
                n_fail++;
                $display("FAIL cont_ready c%0d: got %b want %b",
                         c, sym_ready, c < 4);
            end
            sym_valid = (c < 4);
            sym_data  = (c < 4) ? syms[c] : 2'b00;
            @(negedge clk);
        end
        n_checks++;
        if (bmu_data !== 2'b00) begin
            n_fail++;
            $display("FAIL cont_hold: got %b want 00", bmu_data);
        end
    endtask

    // Entered one cycle after the tb_start pulse.
    task automatic test_tb_done();
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_early k%0d: got %b want 0", k, frame_done);
            end
            if (k == 3) tb_done = 1'b1;
            @(negedge clk);
        end
        tb_done = 1'b0;
        n_checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: fd %b busy %b want 1 1", frame_done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_idle: fd %b busy %b want 0 0", frame_done, busy);
        end
    endtask

    task automatic test_gap();
        logic [1:0] syms [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        logic       vtab [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0};
        logic [2:0] atab [11] = '{0, 0, 0, 1, 0, 2, 0, 3, 4, 5, 0};
        logic [1:0] dtab [11] = '{0, 3, 0, 1, 0, 2, 0, 3, 0, 0, 0};
        int         wr = 0;
        start_frame();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) begin
                n_checks++;
                if (pm_valid !== vtab[c]) begin
                    n_fail++;
                    $display("FAIL gap_valid c%0d: got %b want %b",
                             c, pm_valid, vtab[c]);
                end
                if (vtab[c]) begin
                    n_checks++;
                    if (surv_waddr !== atab[c] || bmu_data !== dtab[c]) begin
                        n_fail++;
                        $display("FAIL gap_data c%0d: a %0d d %b want %0d %b",
                                 c, surv_waddr, bmu_data, atab[c], dtab[c]);
                    end
                end
                if (pm_valid === 1'b1 && surv_waddr < AW'(FL)) wr++;
                n_checks++;
                if (tb_start !== (c == 10)) begin
                    n_fail++;
                    $display("FAIL gap_tbstart c%0d: got %b want %b",
                             c, tb_start, c == 10);
                end
            end
            sym_valid = (c < 8) && (c % 2 == 0);
            sym_data  = (c < 8) ? syms[c/2] : 2'b00;
            @(negedge clk);
        end
        n_checks++;
        if (wr !== FL) begin
            n_fail++;
            $display("FAIL gap_writes: got %0d want %0d", wr, FL);
        end
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_done: got %b want 1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [12:0] got;
        start_frame();
        sym_valid = 1'b1;
        sym_data  = 2'b01;
        @(negedge clk);
        sym_data  = 2'b11;
        @(negedge clk);
        sym_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        got = {sym_ready, bmu_data, pm_valid, pm_init, surv_we,
               surv_waddr, tb_start, frame_done, busy};
        n_checks++;
        if (got !== 13'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b want 0", got);
        end
        @(negedge clk);
        n_checks++;
        if (pm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_nowrite: got %b want 0", pm_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();
        sym_valid = 1'b1;
        sym_data  = 2'b10;
        @(negedge clk);
        sym_valid = 1'b0;
        n_checks++;
        if (pm_valid !== 1'b1 || surv_waddr !== 3'd0 || bmu_data !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_restart: v %b a %0d d %b want 1 0 10",
                     pm_valid, surv_waddr, bmu_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        bit seen = 1'b0;
        bit fd_seen = 1'b0;
        start_frame();
        for (int c = 0; c < 4; c++) begin
            sym_valid = 1'b1;
            sym_data  = 2'(c);
            @(negedge clk);
        end
        sym_valid = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (tb_start === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL to_tbstart: got none want pulse");
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_seen = 1'b1;
            n_checks++;
            if (err !== (k >= 9) || busy !== (k <= 8)) begin
                n_fail++;
                $display("FAIL to_err k%0d: err %b busy %b want %b %b",
                         k, err, busy, k >= 9, k <= 8);
            end
        end
        n_checks++;
        if (fd_seen) begin
            n_fail++;
            $display("FAIL to_nodone: got 1 want 0");
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: got %b want 0", err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_tb_done();
        test_gap();
        test_reset_mid();
`ifdef VITERBI_FRAME_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
